ddr3_clk_rst_seq: RTL and testbench
===================================

// Module: ddr3_clk_rst_seq
// PURPOSE
//   Bring-up and supervision sequencer for the DDR3 clock PLL. Pulses the PLL
//   reset, waits for lock, qualifies lock as stable, then releases the DDR3
//   controller reset after a settle delay. Watches for lock loss, retries a
//   bounded number of times, and flags a hard failure. Sits between the PLL
//   wrapper (pll_rst/pll_lock) and the DDR3 controller reset/ready inputs.
// PARAMETERS
//   RST_CYCLES    16     cycles pll_rst_o is held high per attempt (>=1)
//   LOCK_TIMEOUT  65536  max cycles in WAIT_LOCK before an attempt fails (>=1)
//   LOCK_STABLE   1024   consecutive locked cycles required in STABLE (>=1)
//   DDR_RST_DELAY 256    cycles from stable lock to ddr_rst_n_o release (>=1)
//   MAX_RETRY     3      retries after the first attempt before FAIL (>=0)
// PORTS
//   clk           in   1  sequencer clock (PLL-independent reference clock)
//   rst_n         in   1  asynchronous active-low reset
//   enable_i      in   1  level; 1 = run sequence, 0 = return to IDLE
//   pll_lock_i    in   1  PLL lock, asynchronous to clk
//   pll_rst_o     out  1  PLL reset, active high
//   ddr_rst_n_o   out  1  DDR3 controller reset, active low
//   ready_o       out  1  1 only in RUN
//   error_o       out  1  1 only in FAIL
//   retry_cnt_o   out  2  retries consumed in the current bring-up (saturates at 3)
//   state_o       out  3  current state encoding (debug)
// BEHAVIOUR
//   - All outputs registered. Reset values: state IDLE, pll_rst_o=1,
//     ddr_rst_n_o=0, ready_o=0, error_o=0, retry_cnt_o=0, counter=0.
//   - pll_lock_i passes a 2-flop synchronizer -> lock_s (2-cycle latency).
//   - States: IDLE=0 PLL_RST=1 WAIT_LOCK=2 STABLE=3 DDR_RST=4 RUN=5 FAIL=6.
//   - One shared counter, width clog2 of the largest timing param; cleared on
//     every state change. A timed state lasts exactly N cycles.
//   - enable_i==0 has top priority: next state IDLE from any state; clears
//     retry_cnt and error_o.
//   - IDLE: pll_rst_o=1. enable_i=1 -> PLL_RST.
//   - PLL_RST: pll_rst_o=1 for RST_CYCLES cycles -> WAIT_LOCK.
//   - WAIT_LOCK: pll_rst_o=0. lock_s=1 -> STABLE. Counter reaching
//     LOCK_TIMEOUT-1 with lock_s=0 -> RETRY decision.
//   - STABLE: lock_s held for LOCK_STABLE cycles -> DDR_RST; any lock_s=0
//     -> RETRY decision (a glitch counts as a failed attempt).
//   - DDR_RST: DDR_RST_DELAY cycles -> RUN. ddr_rst_n_o stays 0.
//   - RUN: ddr_rst_n_o=1, ready_o=1 (both rise on the RUN-entry edge).
//     lock_s=0 -> PLL_RST with retry_cnt reset to 0 (fresh bring-up);
//     ddr_rst_n_o/ready_o drop on that same edge.
//   - RETRY decision: retry_cnt==MAX_RETRY -> FAIL; else retry_cnt+1, PLL_RST.
//   - FAIL: pll_rst_o=1, ddr_rst_n_o=0, error_o=1; held until enable_i=0.
//   - ddr_rst_n_o=0 and ready_o=0 in every state except RUN.
//   - rst_n low at any time: all outputs to reset values immediately.
// TESTING
//   1 Defaults, enable_i=1, pll_lock_i rises 100 cycles into WAIT_LOCK and
//     holds -> ready_o/ddr_rst_n_o rise exactly 1283 cycles after lock edge
//     (2 sync + 1 + 1024 + 256); retry_cnt_o=0.
//   2 LOCK_TIMEOUT=64, lock never asserts -> 4 pll_rst_o pulses of 16 cycles,
//     then error_o=1, retry_cnt_o=3, state_o=6, pll_rst_o=1.
//   3 Lock drops 1 cycle mid-STABLE -> retry_cnt_o=1, pll_rst_o high 16
//     cycles, sequence completes to RUN on steady relock.
//   4 In RUN, lock falls -> ddr_rst_n_o=0, ready_o=0 3 cycles later,
//     retry_cnt_o=0, state_o=1; relock returns to RUN.
//   5 enable_i=0 in WAIT_LOCK -> next cycle state_o=0, pll_rst_o=1; in FAIL
//     -> error_o clears; re-enable restarts from PLL_RST.
//   6 rst_n pulsed low mid-RUN between edges -> outputs at reset values before
//     next clk edge; restart requires enable_i=1.

Source files
------------

// File: rtl/ddr3_clk_rst_seq.sv
// DDR3 clock PLL bring-up sequencer: PLL reset pulse, lock qualification,
// DDR controller reset release, lock-loss supervision with bounded retries.
module ddr3_clk_rst_seq #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int LOCK_STABLE   = 1024,
    parameter int DDR_RST_DELAY = 256,
    parameter int MAX_RETRY     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_i,
    input  logic       pll_lock_i,
    output logic       pll_rst_o,
    output logic       ddr_rst_n_o,
    output logic       ready_o,
    output logic       error_o,
    output logic [1:0] retry_cnt_o,
    output logic [2:0] state_o
);

    localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B = (LOCK_STABLE > DDR_RST_DELAY) ? LOCK_STABLE : DDR_RST_DELAY;
    localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = (MAX_T > 2) ? $clog2(MAX_T) : 1;
    localparam int RW    = (MAX_RETRY > 3) ? $clog2(MAX_RETRY + 1) : 2;

    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] DDR_LAST = CW'(DDR_RST_DELAY - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLL_RST   = 3'd1,
        WAIT_LOCK = 3'd2,
        STABLE    = 3'd3,
        DDR_RST   = 3'd4,
        RUN       = 3'd5,
        FAIL      = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [1:0]      retry_sat;
    logic            cnt_en;
    logic            attempt_fail;
    logic            lock_m, lock_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_lock_i;
            lock_s <= lock_m;
        end
    end

    always_comb begin
        state_d      = state_q;
        retry_d      = retry_q;
        cnt_en       = 1'b0;
        attempt_fail = 1'b0;
        if (!enable_i) begin
            state_d = IDLE;
            retry_d = '0;
        end else begin
            unique case (state_q)
                IDLE: state_d = PLL_RST;
                PLL_RST: begin
                    if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
                    else cnt_en = 1'b1;
                end
                WAIT_LOCK: begin
                    if (lock_s) state_d = STABLE;
                    else if (cnt_q == TO_LAST) attempt_fail = 1'b1;
                    else cnt_en = 1'b1;
                end
                STABLE: begin
                    if (!lock_s) attempt_fail = 1'b1;
                    else if (cnt_q == STB_LAST) state_d = DDR_RST;
                    else cnt_en = 1'b1;
                end
                DDR_RST: begin
                    if (cnt_q == DDR_LAST) state_d = RUN;
                    else cnt_en = 1'b1;
                end
                RUN: begin
                    // lock loss after bring-up starts a fresh sequence
                    if (!lock_s) begin
                        state_d = PLL_RST;
                        retry_d = '0;
                    end
                end
                FAIL: state_d = FAIL;
                default: state_d = IDLE;
            endcase
            if (attempt_fail) begin
                if (retry_q == RETRY_MAX) begin
                    state_d = FAIL;
                end else begin
                    retry_d = retry_q + 1'b1;
                    state_d = PLL_RST;
                end
            end
        end
        if (state_d != state_q) cnt_d = '0;
        else if (cnt_en) cnt_d = cnt_q + 1'b1;
        else cnt_d = cnt_q;
        retry_sat = (retry_d > RW'(3)) ? 2'd3 : retry_d[1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_rst_o   <= 1'b1;
            ddr_rst_n_o <= 1'b0;
            ready_o     <= 1'b0;
            error_o     <= 1'b0;
            retry_cnt_o <= 2'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_o   <= (state_d == IDLE) || (state_d == PLL_RST) ||
                           (state_d == FAIL);
            ddr_rst_n_o <= (state_d == RUN);
            ready_o     <= (state_d == RUN);
            error_o     <= (state_d == FAIL);
            retry_cnt_o <= retry_sat;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_ddr3_clk_rst_seq.sv
// Scoreboard bench for ddr3_clk_rst_seq: default-timing instance plus a
// short-timeout instance for the retry/fail path.
module tb_ddr3_clk_rst_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       a_en, a_lock, a_pll_rst, a_ddr_rst_n, a_ready, a_error;
    logic [1:0] a_retry;
    logic [2:0] a_state;
    logic       b_en, b_lock, b_pll_rst, b_ddr_rst_n, b_ready, b_error;
    logic [1:0] b_retry;
    logic [2:0] b_state;

    ddr3_clk_rst_seq u_a (
        .clk(clk), .rst_n(rst_n), .enable_i(a_en), .pll_lock_i(a_lock),
        .pll_rst_o(a_pll_rst), .ddr_rst_n_o(a_ddr_rst_n), .ready_o(a_ready),
        .error_o(a_error), .retry_cnt_o(a_retry), .state_o(a_state)
    );

    ddr3_clk_rst_seq #(.LOCK_TIMEOUT(64)) u_b (
        .clk(clk), .rst_n(rst_n), .enable_i(b_en), .pll_lock_i(b_lock),
        .pll_rst_o(b_pll_rst), .ddr_rst_n_o(b_ddr_rst_n), .ready_o(b_ready),
        .error_o(b_error), .retry_cnt_o(b_retry), .state_o(b_state)
    );

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input int got);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_empty", got, -1);
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, got, e.val);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_a_state(input int st, input int lim, output int n);
        n = 0;
        while (int'(a_state) != st && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_a_ready(input logic v, input int lim, output int n);
        n = 0;
        while (a_ready !== v && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hi, lo, cyc;
        rst_n  = 1'b0;
        a_en   = 1'b0;
        a_lock = 1'b0;
        b_en   = 1'b0;
        b_lock = 1'b0;
        tick(3);
        chk("rst_state", a_state, 0);
        chk("rst_pll_rst", a_pll_rst, 1);
        chk("rst_ddr_rst_n", a_ddr_rst_n, 0);
        chk("rst_ready", a_ready, 0);
        chk("rst_error", a_error, 0);
        chk("rst_retry", a_retry, 0);
        rst_n = 1'b1;
        tick(2);

        // 1: clean bring-up, lock 100 cycles into WAIT_LOCK
        a_en = 1'b1;
        sb_push("t1_enter", 1);
        sb_push("t1_rst_len", 16);
        sb_push("t1_lat", 1283);
        wait_a_state(1, 10, n);
        sb_check(n);
        wait_a_state(2, 40, n);
        sb_check(n);
        chk("t1_wait_pll_rst", a_pll_rst, 0);
        tick(100);
        a_lock = 1'b1;
        wait_a_ready(1'b1, 2000, n);
        sb_check(n);
        chk("t1_ddr_rst_n", a_ddr_rst_n, 1);
        chk("t1_retry", a_retry, 0);
        chk("t1_state", a_state, 5);

        // 4: lock loss in RUN
        a_lock = 1'b0;
        sb_push("t4_drop_lat", 3);
        sb_push("t4_relock", 1297);
        wait_a_ready(1'b0, 10, n);
        sb_check(n);
        chk("t4_ddr_rst_n", a_ddr_rst_n, 0);
        chk("t4_retry", a_retry, 0);
        chk("t4_state", a_state, 1);
        a_lock = 1'b1;
        wait_a_ready(1'b1, 2000, n);
        sb_check(n);

        // 3: single-cycle glitch mid-STABLE
        a_lock = 1'b0;
        sb_push("t3_to_rst", 3);
        sb_push("t3_to_wait", 16);
        sb_push("t3_to_stable", 3);
        sb_push("t3_glitch_lat", 2);
        sb_push("t3_pll_rst_len", 16);
        sb_push("t3_relock", 1281);
        wait_a_state(1, 10, n);
        sb_check(n);
        wait_a_state(2, 40, n);
        sb_check(n);
        tick(5);
        a_lock = 1'b1;
        wait_a_state(3, 10, n);
        sb_check(n);
        tick(500);
        a_lock = 1'b0;
        tick(1);
        a_lock = 1'b1;
        wait_a_state(1, 10, n);
        sb_check(n);
        chk("t3_retry", a_retry, 1);
        n = 0;
        while (a_pll_rst && n < 40) begin
            @(negedge clk);
            n++;
        end
        sb_check(n);
        wait_a_ready(1'b1, 2000, n);
        sb_check(n);
        chk("t3_run_retry", a_retry, 1);

        // 5a: disable while in WAIT_LOCK
        a_lock = 1'b0;
        sb_push("t5_to_wait", 19);
        wait_a_state(2, 40, n);
        sb_check(n);
        tick(10);
        a_en = 1'b0;
        tick(1);
        chk("t5_state", a_state, 0);
        chk("t5_pll_rst", a_pll_rst, 1);
        chk("t5_retry", a_retry, 0);

        // 2: lock never asserts, short timeout
        for (int i = 0; i < 4; i++) begin
            sb_push("t2_pulse", 16);
            sb_push("t2_gap", 64);
        end
        b_en = 1'b1;
        hi = 0;
        lo = 0;
        cyc = 0;
        while (!b_error && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (b_state == 3'd1 && b_pll_rst) hi++;
            else if (hi > 0) begin
                sb_check(hi);
                hi = 0;
            end
            if (!b_pll_rst) lo++;
            else if (lo > 0) begin
                sb_check(lo);
                lo = 0;
            end
        end
        chk("t2_sb_left", sb_q.size(), 0);
        chk("t2_error", b_error, 1);
        chk("t2_retry", b_retry, 3);
        chk("t2_state", b_state, 6);
        chk("t2_pll_rst", b_pll_rst, 1);
        chk("t2_ready", b_ready, 0);
        chk("t2_ddr_rst_n", b_ddr_rst_n, 0);

        // 5b: disable clears FAIL, re-enable restarts
        b_en = 1'b0;
        tick(1);
        chk("t5_fail_error", b_error, 0);
        chk("t5_fail_state", b_state, 0);
        chk("t5_fail_retry", b_retry, 0);
        b_en = 1'b1;
        tick(1);
        chk("t5_restart", b_state, 1);
        b_en = 1'b0;

        // 6: async reset mid-RUN
        a_en = 1'b1;
        a_lock = 1'b1;
        sb_push("t6_bringup", 1298);
        wait_a_ready(1'b1, 2000, n);
        sb_check(n);
        #2;
        rst_n = 1'b0;
        a_en = 1'b0;
        #1;
        chk("t6_state", a_state, 0);
        chk("t6_pll_rst", a_pll_rst, 1);
        chk("t6_ddr_rst_n", a_ddr_rst_n, 0);
        chk("t6_ready", a_ready, 0);
        chk("t6_error", a_error, 0);
        chk("t6_retry", a_retry, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(5);
        chk("t6_idle_hold", a_state, 0);
        a_en = 1'b1;
        tick(1);
        chk("t6_restart", a_state, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
